// File: rtl/upsample_pkg.sv
// Shared types and width helpers for the 2-D pixel upsampler.
package upsample_pkg;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Counter width for a 0..range-1 count, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned range);
        return (range <= 1) ? 1 : $clog2(range);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Simple dual-port line store: one write port, one registered read port.
module line_buffer #(
    parameter int unsigned depth      = 4,
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] rd_data_q;
    logic [data_width-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data holds while rd_en is low so it can drive a stalled output.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/upsample_2d.sv
// Pixel-replicating 2-D upsampler: buffers one decimated row, then replays it
// dec_factor times with each pixel repeated dec_factor times.
module upsample_2d
    import upsample_pkg::*;
#(
    parameter int unsigned dec_factor = 2,
    parameter int unsigned out_width  = 240,
    parameter int unsigned out_height = 480,
    parameter int unsigned data_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int unsigned in_width  = out_width / dec_factor;
    localparam int unsigned in_height = out_height / dec_factor;
    localparam int unsigned addr_w    = cnt_width(in_width);
    localparam int unsigned rep_w     = cnt_width(dec_factor);
    localparam int unsigned row_w     = cnt_width(in_height);

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                fetch_done_q, fetch_done_d;
    logic [addr_w-1:0]   wr_addr_q, wr_addr_d;
    logic [addr_w-1:0]   rd_addr_q, rd_addr_d;
    logic [rep_w-1:0]    pix_rep_q, pix_rep_d;
    logic [rep_w-1:0]    line_rep_q, line_rep_d;
    logic [row_w-1:0]    row_q, row_d;
    logic                rd_en;

    logic in_xfer, out_xfer, fill_done, emit_done, fetch_en;
    logic last_pix, last_col, last_line, last_row, last_fetch;

    assign in_xfer    = in_valid & in_ready_q;
    assign out_xfer   = out_valid_q & out_ready;
    assign fill_done  = in_xfer & (wr_addr_q == addr_w'(in_width - 1));
    assign emit_done  = out_xfer & fetch_done_q;
    // Fetch the next pixel whenever the output register is empty or draining.
    assign fetch_en   = (state_q == EMIT) & ~fetch_done_q & (~out_valid_q | out_ready);
    assign last_pix   = (pix_rep_q == rep_w'(dec_factor - 1));
    assign last_col   = (rd_addr_q == addr_w'(in_width - 1));
    assign last_line  = (line_rep_q == rep_w'(dec_factor - 1));
    assign last_row   = (row_q == row_w'(in_height - 1));
    assign last_fetch = last_pix & last_col & last_line;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            fetch_done_q <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            pix_rep_q    <= '0;
            line_rep_q   <= '0;
            row_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            fetch_done_q <= fetch_done_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            pix_rep_q    <= pix_rep_d;
            line_rep_q   <= line_rep_d;
            row_q        <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (fill_done) state_d = EMIT;
            EMIT:    if (emit_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready_d   = (state_d == FILL);
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        fetch_done_d = fetch_done_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        pix_rep_d    = pix_rep_q;
        line_rep_d   = line_rep_q;
        row_d        = row_q;
        rd_en        = 1'b0;

        if (in_xfer) begin
            wr_addr_d = fill_done ? '0 : wr_addr_q + addr_w'(1);
        end

        if (emit_done) begin
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            fetch_done_d = 1'b0;
            row_d        = last_row ? '0 : row_q + row_w'(1);
        end else if (fetch_en) begin
            rd_en        = 1'b1;
            out_valid_d  = 1'b1;
            out_last_d   = last_fetch & last_row;
            fetch_done_d = last_fetch;
            // Pixel repeat is innermost, then column, then repeated line.
            if (!last_pix) begin
                pix_rep_d = pix_rep_q + rep_w'(1);
            end else begin
                pix_rep_d = '0;
                if (!last_col) begin
                    rd_addr_d = rd_addr_q + addr_w'(1);
                end else begin
                    rd_addr_d  = '0;
                    line_rep_d = last_line ? '0 : line_rep_q + rep_w'(1);
                end
            end
        end
    end

    line_buffer #(
        .depth      (in_width),
        .data_width (data_width),
        .addr_width (addr_w)
    ) u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_xfer),
        .wr_addr (wr_addr_q),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (out_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_upsample_2d.sv
// Randomized bench for upsample_2d against a queue-based replication model.
module tb_upsample_2d;

    localparam int DEC   = 2;
    localparam int OUT_W = 8;
    localparam int OUT_H = 4;
    localparam int IN_W  = OUT_W / DEC;
    localparam int FRAME = OUT_W * OUT_H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;

    logic [7:0] b_in_data = '0;
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_out_data;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic       b_out_last;

    upsample_2d #(
        .dec_factor (DEC),
        .out_width  (OUT_W),
        .out_height (OUT_H),
        .data_width (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    upsample_2d #(
        .dec_factor (1),
        .out_width  (4),
        .out_height (2),
        .data_width (8)
    ) dut_pass (
        .clk       (clk),
        .reset     (reset),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_last  (b_out_last)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int fill_cyc = -100;
    int n_out = 0;
    int prev_last = -1;
    int frame_out_cnt = 0;
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] acc[$];
    bit         stall_pend = 1'b0;
    logic [7:0] hold_d;
    logic       hold_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A full decimated row expands into DEC lines of each pixel repeated DEC times.
    task automatic model_accept(input logic [7:0] d);
        acc.push_back(d);
        if (acc.size() == IN_W) begin
            for (int ln = 0; ln < DEC; ln++)
                for (int p = 0; p < IN_W; p++)
                    for (int r = 0; r < DEC; r++) begin
                        exp_d.push_back(acc[p]);
                        exp_l.push_back(frame_out_cnt == FRAME - 1);
                        frame_out_cnt = (frame_out_cnt + 1) % FRAME;
                    end
            acc.delete();
            fill_cyc = cyc;
        end
    endtask

    task automatic step(input bit iv, input logic [7:0] id, input bit ordy, output bit accepted);
        logic [7:0] ed;
        bit         el;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        if (stall_pend) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_d);
            check("hold_last", out_last, hold_l);
        end
        check("in_ready", in_ready, exp_d.size() == 0);
        if (exp_d.size() == 0) check("idle_valid", out_valid, 0);
        else if (cyc >= fill_cyc + 2) check("no_bubble", out_valid, 1);
        if (out_valid && out_ready && exp_d.size() != 0) begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            n_out++;
            check("out_data", out_data, ed);
            check("out_last", out_last, el);
            if (out_last) begin
                if (prev_last >= 0) check("last_gap", n_out - prev_last, FRAME);
                prev_last = n_out;
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) model_accept(in_data);
        stall_pend = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        exp_d.delete();
        exp_l.delete();
        acc.delete();
        frame_out_cnt = 0;
        stall_pend    = 1'b0;
        prev_last     = -1;
        @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // rdy_mode: 0 always, 1 toggle, 2 random; iv_mode: 0 continuous, 1 random.
    task automatic run(input int n_in, input bit rnd, input int base, input int rdy_mode,
                       input int iv_mode, input int stop_after);
        logic [7:0] src[$];
        int  idx = 0;
        int  start = n_out;
        bit  done = 1'b0;
        bit  acc_ok;
        bit  iv, ordy;
        for (int i = 0; i < n_in; i++) src.push_back(rnd ? 8'($urandom) : 8'(base + i));
        for (int b = 0; b < 4000; b++) begin
            if (stop_after >= 0 && n_out - start >= stop_after) begin done = 1'b1; break; end
            if (idx >= n_in && exp_d.size() == 0) begin done = 1'b1; break; end
            iv   = (idx < n_in) && (iv_mode == 0 || $urandom_range(0, 1) == 1);
            ordy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            step(iv, (idx < n_in) ? src[idx] : 8'h00, ordy, acc_ok);
            if (acc_ok) idx++;
        end
        if (!done) check("timeout_done", 32'(done), 1);
        if (stop_after < 0) check("out_count", n_out - start, n_in * DEC * DEC);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] psrc[8];
        int idx, oi;
        @(negedge clk);
        do_reset();
        run(8, 1'b0, 0, 0, 0, -1);      // rows 0..3 and 4..7, ready held high
        run(8, 1'b0, 0, 1, 0, -1);      // same data with out_ready toggling
        run(8, 1'b1, 0, 0, 0, -1);      // random data, in_valid held high
        run(8, 1'b1, 0, 0, 0, 10);      // abandon after 10 outputs
        do_reset();
        run(8, 1'b0, 100, 0, 0, -1);    // fresh frame 100..107
        run(16, 1'b1, 0, 0, 0, -1);     // two back-to-back frames
        run(24, 1'b1, 0, 2, 1, -1);     // random ready and valid

        // Pass-through instance: output must equal input, last on 8th pixel.
        for (int i = 0; i < 8; i++) psrc[i] = 8'($urandom);
        idx = 0;
        oi  = 0;
        for (int b = 0; b < 200 && oi < 8; b++) begin
            b_in_valid  = (idx < 8);
            b_in_data   = (idx < 8) ? psrc[idx] : 8'h00;
            b_out_ready = 1'b1;
            #1;
            if (b_out_valid && b_out_ready) begin
                check("pass_data", b_out_data, psrc[oi]);
                check("pass_last", b_out_last, oi == 7);
                oi++;
            end
            if (b_in_valid && b_in_ready) idx++;
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        check("pass_count", oi, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
